// File: rtl/led_sequencer.sv
// Command-loaded 4-step LED pattern player with programmable step rate,
// finite/infinite repeat count and global PWM brightness for three LEDs.
module led_sequencer #(
    parameter int BASE_SHIFT = 16,
    parameter int PWM_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [11:0]      cmd_pattern,
    input  logic [3:0]       cmd_rate,
    input  logic [3:0]       cmd_repeat,
    input  logic [PWM_W-1:0] cmd_bright,
    output logic             led1,
    output logic             led2,
    output logic             led3,
    output logic             busy,
    output logic             done
);

    localparam int TW = BASE_SHIFT + 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             done_nxt;

    logic [11:0]      pattern_r;
    logic [3:0]       rate_r;
    logic [PWM_W-1:0] bright_r;

    logic [3:0]       remain;
    logic [1:0]       step;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    dur_last;
    logic [PWM_W-1:0] pwm_cnt;

    logic             accept;
    logic             expiry;
    logic             pass_end;
    logic             finish;
    logic [2:0]       step_bits;
    logic [2:0]       led_p0;

    assign cmd_ready = ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state == RUN);

    assign dur_last = (TW'(1) << (BASE_SHIFT + int'(rate_r))) - TW'(1);
    assign expiry   = (state == RUN) && (timer == dur_last);
    assign pass_end = expiry && (step == 2'd3);
    assign finish   = pass_end && (remain == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // A new command always wins over completion, so an accept on the final
    // expiry edge keeps the block running and suppresses done.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (accept) begin
                    state_nxt = RUN;
                end else if (finish) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            step    <= 2'd0;
            remain  <= 4'd0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (accept) begin
                timer  <= '0;
                step   <= 2'd0;
                remain <= cmd_repeat;
            end else if (expiry) begin
                timer <= '0;
                step  <= step + 2'd1;
                if (pass_end && (remain > 4'd1)) remain <= remain - 4'd1;
            end else if (state == RUN) begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pattern_r <= cmd_pattern;
            rate_r    <= cmd_rate;
            bright_r  <= cmd_bright;
        end
    end

    always_comb begin
        step_bits = 3'b000;
        case (step)
            2'd0: step_bits = pattern_r[2:0];
            2'd1: step_bits = pattern_r[5:3];
            2'd2: step_bits = pattern_r[8:6];
            2'd3: step_bits = pattern_r[11:9];
            default: step_bits = 3'b000;
        endcase
    end

    assign led_p0 = step_bits & {3{state == RUN}} & {3{bright_r > pwm_cnt}};

    // Output register stage: LEDs trail internal state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            led1 <= 1'b0;
            led2 <= 1'b0;
            led3 <= 1'b0;
        end else begin
            led1 <= led_p0[0];
            led2 <= led_p0[1];
            led3 <= led_p0[2];
        end
    end

endmodule
